// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-side master for the 32x32 register file.
// Merges a single-cycle ALU writeback stream with a long-latency memory/mul
// stream buffered in a small circular FIFO. It also keeps a pending-destination
// scoreboard so that issue logic can stall on RAW hazards against
// long-latency ops.
// Optional feature: define WB_BYPASS_EN to let a memory-path request skip
// the empty FIFO when the ALU does not win, giving single-cycle latency.
module regfile_wb_arbiter #(
  parameter int MEM_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic [31:0]     pending,
  output logic            we3,
  output logic [4:0]      wa3,
  output logic [XLEN-1:0] wd3
);

  // MEM_DEPTH is a power of two, so pointers wrap by natural overflow.
  localparam int PW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = PW + 1;

  // One-hot register mask; x0 never appears in the scoreboard.
  function automatic logic [31:0] rd_mask(input logic [4:0] rd);
    logic [31:0] m;
    m = 32'd1 << rd;
    m[0] = 1'b0;
    return m;
  endfunction

  // FIFO storage and control
  logic [4:0]      fifo_rd   [MEM_DEPTH];
  logic [XLEN-1:0] fifo_data [MEM_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic            fifo_empty;

  // Arbitration results for the current cycle
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            sel_mem;
  logic            pop;
  logic            bypass;
  logic            push;

  // Scoreboard
  logic [31:0]     pending_q;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  // Registered write port
  logic            we_p1;
  logic [4:0]      wa_p1;
  logic [XLEN-1:0] wd_p1;

  assign fifo_full  = (count == CW'(MEM_DEPTH));
  assign fifo_empty = (count == '0);

  // Both producers are held off while in reset or while the FIFO is full.
  // A full FIFO never accepts a push, even in a cycle where it pops.
  assign alu_ready = rst_n && !fifo_full;
  assign mem_ready = rst_n && !fifo_full;

  // Pick the single regfile writer for this cycle.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    sel_mem   = 1'b0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (rst_n) begin
      if (fifo_full) begin
        // A full FIFO drains ahead of the ALU so the memory path cannot starve.
        sel_valid = 1'b1;
        sel_rd    = fifo_rd[head];
        sel_data  = fifo_data[head];
        sel_mem   = 1'b1;
        pop       = 1'b1;
      end else if (alu_valid) begin
        sel_valid = 1'b1;
        sel_rd    = alu_rd;
        sel_data  = alu_data;
      end else if (!fifo_empty) begin
        sel_valid = 1'b1;
        sel_rd    = fifo_rd[head];
        sel_data  = fifo_data[head];
        sel_mem   = 1'b1;
        pop       = 1'b1;
      end
`ifdef WB_BYPASS_EN
      else if (mem_valid) begin
        // Empty FIFO and idle ALU: forward the memory request directly.
        sel_valid = 1'b1;
        sel_rd    = mem_rd;
        sel_data  = mem_data;
        sel_mem   = 1'b1;
        bypass    = 1'b1;
      end
`endif
    end
  end

  // A bypassed request is consumed directly and never enters the FIFO.
  assign push = mem_valid && mem_ready && !bypass;

  // Scoreboard masks: issue sets, a memory-path retire clears.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid) begin
      set_mask = rd_mask(issue_rd);
    end
    if (sel_valid && sel_mem) begin
      clr_mask = rd_mask(sel_rd);
    end
  end

  // FIFO pointers and occupancy; reset flushes any buffered entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= mem_rd;
      fifo_data[tail] <= mem_data;
    end
  end

  // Pending scoreboard; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  assign pending = pending_q;

  // ---- stage p1: registered regfile write port ----
  // Writes to x0 are consumed but suppressed; address and data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_p1 <= 1'b0;
      wa_p1 <= '0;
      wd_p1 <= '0;
    end else begin
      we_p1 <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        wa_p1 <= sel_rd;
        wd_p1 <= sel_data;
      end
    end
  end

  assign we3 = we_p1;
  assign wa3 = wa_p1;
  assign wd3 = wd_p1;

endmodule
